// File: rtl/ex_div.sv
// rtl/ex_div.sv - iterative RV32M DIV/DIVU/REM/REMU unit with pipeline stall request.
// Optional DIV_EARLY_OUT_EN: one-cycle completion when |dividend| < |divisor|.
module ex_div #(
   parameter int DATA_W = 32,
   parameter int ITER_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [1:0]        op_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   input  logic [4:0]        rd_i,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              ready_o,
   output logic [DATA_W-1:0] result_o,
   output logic [4:0]        rd_o,
   output logic              stall_req_o
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ITER_W-1:0]   cnt_q;
   logic [DATA_W:0]     rem_q;
   logic [DATA_W-1:0]   quo_q;
   logic [DATA_W-1:0]   dvs_q;
   logic                rem_sel_q;
   logic                qneg_q;
   logic                rneg_q;
   logic [4:0]          rd_q;
   logic                busy_q;
   logic                ready_q;
   logic [DATA_W-1:0]   result_q;
   logic [4:0]          rd_out_q;

   logic                accept;
   logic                calc_en;
   logic                signed_op;
   logic                dvd_neg, dvs_neg;
   logic [DATA_W-1:0]   abs_dvd, abs_dvs;
   logic                div_zero, ovf, early, fast;
   logic [DATA_W-1:0]   fast_res;
   logic [DATA_W:0]     rem_sh, rem_n;
   logic [DATA_W-1:0]   quo_n;
   logic                geq;
   logic [DATA_W-1:0]   q_fix, r_fix, calc_res;

   // Start-cycle operand conditioning and fast-path detection
   always_comb begin
      signed_op = ~op_i[0];
      dvd_neg   = signed_op & dividend_i[DATA_W-1];
      dvs_neg   = signed_op & divisor_i[DATA_W-1];
      abs_dvd   = dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
      abs_dvs   = dvs_neg ? (~divisor_i + 1'b1) : divisor_i;
      div_zero  = (divisor_i == '0);
      ovf       = signed_op & (dividend_i == {1'b1, {(DATA_W-1){1'b0}}}) & (divisor_i == '1);
`ifdef DIV_EARLY_OUT_EN
      early     = ~div_zero & ~ovf & (abs_dvd < abs_dvs);
`else
      early     = 1'b0;
`endif
      fast      = div_zero | ovf | early;
      if (div_zero)
         fast_res = op_i[1] ? dividend_i : '1;
      else if (ovf)
         fast_res = op_i[1] ? '0 : dividend_i;
      else
         fast_res = op_i[1] ? dividend_i : '0;
   end

   // One restoring step; the final step also feeds the sign fix-up directly
   always_comb begin
      rem_sh   = (DATA_W+1)'({rem_q, quo_q[DATA_W-1]});
      geq      = (rem_sh >= {1'b0, dvs_q});
      rem_n    = geq ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
      quo_n    = {quo_q[DATA_W-2:0], geq};
      q_fix    = qneg_q ? (~quo_n + 1'b1) : quo_n;
      r_fix    = rneg_q ? (~rem_n[DATA_W-1:0] + 1'b1) : rem_n[DATA_W-1:0];
      calc_res = rem_sel_q ? r_fix : q_fix;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_i) state_d = fast ? S_DONE : S_CALC;
         S_CALC: if (cnt_q == ITER_W'(DATA_W-1)) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush_i)
         state_d = S_IDLE;
   end

   always_comb begin
      accept      = (state_q == S_IDLE) & start_i & ~flush_i;
      calc_en     = (state_q == S_CALC);
      stall_req_o = accept | (calc_en & ~flush_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         rem_sel_q <= 1'b0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         rd_q      <= '0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
         result_q  <= '0;
         rd_out_q  <= '0;
      end else begin
         busy_q  <= (state_d != S_IDLE);
         ready_q <= (state_d == S_DONE);
         if (accept) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= abs_dvd;
            dvs_q     <= abs_dvs;
            rem_sel_q <= op_i[1];
            qneg_q    <= dvd_neg ^ dvs_neg;
            rneg_q    <= dvd_neg;
            rd_q      <= rd_i;
         end else if (calc_en) begin
            cnt_q <= cnt_q + 1'b1;
            rem_q <= rem_n;
            quo_q <= quo_n;
         end
         if (state_d == S_DONE) begin
            result_q <= (state_q == S_IDLE) ? fast_res : calc_res;
            rd_out_q <= (state_q == S_IDLE) ? rd_i : rd_q;
         end
      end
   end

   assign busy_o   = busy_q;
   assign ready_o  = ready_q;
   assign result_o = result_q;
   assign rd_o     = rd_out_q;

endmodule

// File: doc/ex_div.md
# ex_div

Iterative 32-bit divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting in the execute stage directly downstream of the ID/EX pipeline register. It consumes the operands, ALU op and destination register latched by ID/EX. It holds the pipeline via a stall request while it iterates, then returns one result for EX to write back. A branch flush from EX aborts it.

## Interface
Parameters:
- `DATA_W`, 32: operand/result width; only 32 is supported.
- `ITER_W`, 6: iteration counter width; must hold `DATA_W`.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: division request from EX; sampled only in IDLE.
- `op_i` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `dividend_i` in 32: operand1 from ID/EX.
- `divisor_i` in 32: operand2 from ID/EX.
- `rd_i` in 5: destination register address.
- `flush_i` in 1: branch flush; aborts any operation.
- `busy_o` out 1: registered; high in CALC and DONE.
- `ready_o` out 1: registered; one-cycle result-valid pulse.
- `result_o` out 32: registered; quotient or remainder, valid while `ready_o`.
- `rd_o` out 5: registered; `rd_i` captured at start, valid while `ready_o`.
- `stall_req_o` out 1: combinational; pipeline stall request to the stall controller.

## Operation
- States: IDLE, CALC, DONE.
- IDLE with `start_i` and no `flush_i`:
  - latch `op_i` and `rd_i`;
  - latch |dividend| and |divisor| (absolute values only for signed ops);
  - latch sign flags: quotient negate = sign(dividend) XOR sign(divisor); remainder negate = sign(dividend).
- Fast paths, resolved in the start cycle with the next state going straight to DONE:
  - divisor == 0: quotient = 0xFFFFFFFF, remainder = dividend (raw, no sign fixing).
  - Signed op with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Otherwise go to CALC with counter = 0.
- CALC: restoring radix-2, one quotient bit per cycle.
  - Shift {rem, quo} left by 1.
  - If rem ≥ divisor: subtract, set quo LSB = 1.
  - Remainder register is 33 bits.
  - After 32 iterations (counter == 31 at the edge), go to DONE.
- DONE:
  - `result_o` = (negate ? −x : x) of the quotient for DIV/DIVU, or of the remainder for REM/REMU. Unsigned ops never negate.
  - `ready_o` = 1 for exactly this cycle.
  - Next state is IDLE unconditionally.
- `stall_req_o` = (IDLE & `start_i` & !`flush_i`) | CALC. It is low in DONE, so EX captures the result and the pipeline resumes that cycle.
- `flush_i` in any state: next state is IDLE; `ready_o` stays 0 and no result is produced. Flush has priority over start.
- `start_i` in CALC or DONE is ignored.
- `rst`: state IDLE; `busy_o`, `ready_o` = 0; `result_o` = 0; `rd_o` = 0; internal registers = 0. This applies mid-operation too.

## Timing
- Start sampled at edge N.
- Normal path: CALC spans cycles N+1 … N+32. DONE, with `ready_o`, is cycle N+33.
- Fast path: DONE is cycle N+1.
- `stall_req_o` is high from the start cycle through the last CALC cycle.
- Back-to-back divide: the new `start_i` is accepted only once the block is back in IDLE, at the earliest cycle N+34.
- `result_o` and `rd_o` hold their values after DONE until the next DONE or reset.

## Configuration
- `DIV_EARLY_OUT_EN`:
  - Defined: in the start cycle, if |dividend| < |divisor| (nonzero divisor, overflow case excluded), take the fast path to DONE with quotient 0 and remainder = original dividend. Latency is 1.
  - Undefined: this case runs the full 32 iterations. Results are identical either way.

## Test plan
- DIVU 100 / 7, rd = 5 → `ready_o` at N+33, `result_o` = 14, `rd_o` = 5; `stall_req_o` high N … N+32.
- DIV −7 / 2 = 0xFFFFFFF9 / 2 → 0xFFFFFFFD (−3); REM of the same operands → 0xFFFFFFFF (−1).
- DIV by 0 with dividend 0x1234 → 0xFFFFFFFF at N+1. REMU by 0 → 0x1234 at N+1.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at N+1. REM of the same operands → 0 at N+1.
- Start DIVU, assert `flush_i` at N+10 → IDLE at N+11; no `ready_o` pulse; `stall_req_o` low from N+10. `rst` at N+5 → all outputs 0 next cycle.
- REMU 3 / 10 → 3; latency 1 with `DIV_EARLY_OUT_EN`, 33 without.
